ysyx_24070016_mem_arbiter: RTL and testbench

Two-master, single-outstanding memory arbiter that lets the instruction fetch unit (IFU) and the load/store unit (LSU) share one memory port. It sits between the core and the memory interface and replaces direct IFU-to-memory wiring. It accepts one request, registers it, issues it downstream, waits for the response, routes the response back to the owner, and then re-arbitrates.

---
 rtl/ysyx_24070016_mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_ysyx_24070016_mem_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24070016_mem_arbiter.sv
// Two-master (IFU/LSU), single-outstanding arbiter in front of one memory port.
// Fixed LSU priority by default; define YSYX_24070016_ARB_RR_EN for round-robin.
module ysyx_24070016_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    localparam logic OWNER_IFU = 1'b0;
    localparam logic OWNER_LSU = 1'b1;

    state_e                state_q;
    logic                  owner_q;
    logic                  last_owner_q;
    logic                  mem_req_valid_q;
    logic [ADDR_W-1:0]     mem_addr_q;
    logic                  mem_wen_q;
    logic [DATA_W-1:0]     mem_wdata_q;
    logic [DATA_W/8-1:0]   mem_wmask_q;
    logic                  grant_ifu_s;
    logic                  grant_lsu_s;
    logic                  in_idle_s;
    logic                  in_wait_s;

    // Grant selection among the currently valid requesters
    always_comb begin
        grant_ifu_s = 1'b0;
        grant_lsu_s = 1'b0;
        if (ifu_req_valid && lsu_req_valid) begin
`ifdef YSYX_24070016_ARB_RR_EN
            grant_lsu_s = (last_owner_q == OWNER_IFU);
            grant_ifu_s = (last_owner_q == OWNER_LSU);
`else
            grant_lsu_s = 1'b1;
`endif
        end else begin
            grant_ifu_s = ifu_req_valid;
            grant_lsu_s = lsu_req_valid;
        end
    end

    assign in_idle_s     = (state_q == S_IDLE);
    assign in_wait_s     = (state_q == S_WAIT);
    // Gated by rst so no handshake can be offered while reset is held
    assign ifu_req_ready = !rst && in_idle_s && grant_ifu_s;
    assign lsu_req_ready = !rst && in_idle_s && grant_lsu_s;

    assign ifu_resp_valid = in_wait_s && (owner_q == OWNER_IFU) && mem_resp_valid;
    assign lsu_resp_valid = in_wait_s && (owner_q == OWNER_LSU) && mem_resp_valid;
    assign ifu_rdata      = ifu_resp_valid ? mem_rdata : '0;
    assign lsu_rdata      = lsu_resp_valid ? mem_rdata : '0;

    assign mem_req_valid = mem_req_valid_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wen       = mem_wen_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_wmask     = mem_wmask_q;

    // Transaction FSM with registered downstream request fields
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            owner_q         <= OWNER_IFU;
            last_owner_q    <= OWNER_IFU;
            mem_req_valid_q <= 1'b0;
            mem_addr_q      <= '0;
            mem_wen_q       <= 1'b0;
            mem_wdata_q     <= '0;
            mem_wmask_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_lsu_s) begin
                        owner_q         <= OWNER_LSU;
                        last_owner_q    <= OWNER_LSU;
                        mem_addr_q      <= lsu_addr;
                        mem_wen_q       <= lsu_wen;
                        mem_wdata_q     <= lsu_wdata;
                        mem_wmask_q     <= lsu_wmask;
                        mem_req_valid_q <= 1'b1;
                        state_q         <= S_REQ;
                    end else if (grant_ifu_s) begin
                        owner_q         <= OWNER_IFU;
                        last_owner_q    <= OWNER_IFU;
                        mem_addr_q      <= ifu_addr;
                        mem_wen_q       <= 1'b0;
                        mem_wdata_q     <= '0;
                        mem_wmask_q     <= '0;
                        mem_req_valid_q <= 1'b1;
                        state_q         <= S_REQ;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= S_WAIT;
                    end else begin
                        state_q <= S_REQ;
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                default: begin
                    mem_req_valid_q <= 1'b0;
                    state_q         <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// Protocol checker for the downstream port: a response is only legal while a
// request is outstanding, and never in the cycle the request is accepted.
module ysyx_24070016_mem_arbiter_chk (
    input logic clk,
    input logic rst,
    input logic mem_req_valid,
    input logic mem_req_ready,
    input logic mem_resp_valid
);

    logic outstanding_q;

    // Tracks whether the memory owes a response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding_q <= 1'b0;
        end else if (mem_req_valid && mem_req_ready) begin
            outstanding_q <= 1'b1;
        end else if (mem_resp_valid) begin
            outstanding_q <= 1'b0;
        end else begin
            outstanding_q <= outstanding_q;
        end
    end

    a_resp_only_when_outstanding: assert property (
        @(posedge clk) disable iff (rst) mem_resp_valid |-> outstanding_q
    );

endmodule

// File: tb/tb_ysyx_24070016_mem_arbiter.sv
// Self-checking bench for ysyx_24070016_mem_arbiter: vector table, response scoreboard
// and hand-written sequences for contention, backpressure and reset in WAIT.
`timescale 1ns/1ps
module tb_ysyx_24070016_mem_arbiter;

`ifdef YSYX_24070016_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ifu_req_valid = 1'b0, ifu_req_ready, ifu_resp_valid;
    logic [31:0] ifu_addr = 32'h0, ifu_rdata;
    logic        lsu_req_valid = 1'b0, lsu_req_ready, lsu_resp_valid, lsu_wen = 1'b0;
    logic [31:0] lsu_addr = 32'h0, lsu_wdata = 32'h0, lsu_rdata;
    logic [3:0]  lsu_wmask = 4'h0, mem_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    ysyx_24070016_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    ysyx_24070016_mem_arbiter_chk chk_i (
        .clk(clk), .rst(rst), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rdata_for(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0010_0093;
        return a ^ 32'hA5A5_5A5A;
    endfunction

    // Scoreboard of expected responses (owner, data)
    typedef struct packed { logic lsu; logic [31:0] data; } exp_t;
    exp_t sb[$];
    logic last_m = 1'b0;

    // Memory model: stalls cfg_stall cycles, responds cfg_lat cycles after accept
    int   cfg_stall = 0;
    int   cfg_lat = 1;
    int   stall_c = 0;
    int   wait_c = 0;
    bit   busy = 1'b0;
    logic [31:0] rd_v = 32'h0;
    initial begin
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = 32'h0;
        forever begin
            @(posedge clk); #1;
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            if (rst) begin
                busy = 1'b0; stall_c = 0;
            end else if (busy) begin
                if (wait_c <= 1) begin
                    mem_resp_valid = 1'b1; mem_rdata = rd_v; busy = 1'b0;
                end else begin
                    wait_c--;
                end
            end else if (mem_req_valid) begin
                if (stall_c < cfg_stall) begin
                    stall_c++;
                end else begin
                    mem_req_ready = 1'b1; busy = 1'b1; wait_c = cfg_lat; stall_c = 0;
                    rd_v = rdata_for(mem_addr);
                end
            end
        end
    end

    // Response monitor: pops the scoreboard on every delivered response
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (ifu_resp_valid || lsu_resp_valid)) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL resp_unexpected: ifu=%0b lsu=%0b with none pending",
                             ifu_resp_valid, lsu_resp_valid);
                end else begin
                    e = sb.pop_front();
                    chk("resp_owner", 64'({ifu_resp_valid, lsu_resp_valid}),
                        64'(e.lsu ? 2'b01 : 2'b10));
                    chk("resp_data", 64'(e.lsu ? lsu_rdata : ifu_rdata), 64'(e.data));
                end
            end
        end
    end

    typedef struct {
        logic iv; logic [31:0] ia;
        logic lv; logic [31:0] la; logic lw; logic [31:0] ld; logic [3:0] lm;
        int stall; int lat;
    } vec_t;

    task automatic run_vec(input vec_t v, input string tag);
        logic el, ew;
        logic [31:0] ea;
        logic [3:0] em;
        int acc, got;
        el = v.lv && (!v.iv || !RR || !last_m);
        ea = el ? v.la : v.ia;
        ew = el ? v.lw : 1'b0;
        em = el ? v.lm : 4'h0;
        @(posedge clk); #1;
        cfg_stall = v.stall; cfg_lat = v.lat;
        ifu_req_valid = v.iv; ifu_addr = v.ia;
        lsu_req_valid = v.lv; lsu_addr = v.la; lsu_wen = v.lw; lsu_wdata = v.ld; lsu_wmask = v.lm;
        acc = -1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); #2;
            if (ifu_req_ready || lsu_req_ready) begin acc = c; break; end
        end
        if (acc < 0) begin
            checks++; errors++;
            $display("FAIL %s_accept: no ready within 8 cycles", tag);
            return;
        end
        chk({tag, "_accept_lat"}, 64'(acc), 64'(0));
        chk({tag, "_grant"}, 64'({ifu_req_ready, lsu_req_ready}), 64'(el ? 2'b01 : 2'b10));
        last_m = el;
        sb.push_back('{el, rdata_for(ea)});
        @(posedge clk); #1;
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        got = -1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk); #2;
            chk({tag, "_busy_ready"}, 64'({ifu_req_ready, lsu_req_ready}), 64'(2'b00));
            if (c <= 1 + v.stall) begin
                chk({tag, "_req"}, 64'({mem_req_valid, mem_addr, mem_wen, mem_wmask}),
                    64'({1'b1, ea, ew, em}));
                if (el) chk({tag, "_wdata"}, 64'(mem_wdata), 64'(v.ld));
            end else begin
                chk({tag, "_req_low"}, 64'(mem_req_valid), 64'(0));
            end
            if (sb.size() == 0) begin got = c; break; end
        end
        if (got < 0) sb.delete();
        chk({tag, "_resp_cycle"}, 64'(got), 64'(1 + v.stall + v.lat));
    endtask

    vec_t vecs[8];
    int   got;
    logic el;

    initial begin
        vecs[0] = '{iv:1'b1, ia:32'h8000_0000, lv:1'b0, la:32'h0, lw:1'b0, ld:32'h0, lm:4'h0, stall:0, lat:1};
        vecs[1] = '{iv:1'b0, ia:32'h0, lv:1'b1, la:32'h8000_1000, lw:1'b1, ld:32'hDEAD_BEEF, lm:4'hF, stall:0, lat:1};
        vecs[2] = '{iv:1'b0, ia:32'h0, lv:1'b1, la:32'h8000_2004, lw:1'b0, ld:32'h0, lm:4'h0, stall:0, lat:2};
        vecs[3] = '{iv:1'b1, ia:32'h8000_0010, lv:1'b1, la:32'h8000_3000, lw:1'b1, ld:32'h1234_5678, lm:4'h3, stall:0, lat:1};
        vecs[4] = '{iv:1'b1, ia:32'h8000_0014, lv:1'b1, la:32'h8000_3000, lw:1'b0, ld:32'h0, lm:4'h0, stall:0, lat:2};
        vecs[5] = '{iv:1'b0, ia:32'h0, lv:1'b1, la:32'h8000_4000, lw:1'b1, ld:32'hCAFE_F00D, lm:4'hC, stall:5, lat:3};
        vecs[6] = '{iv:1'b1, ia:32'hFFFF_FFFC, lv:1'b0, la:32'h0, lw:1'b0, ld:32'h0, lm:4'h0, stall:2, lat:4};
        vecs[7] = '{iv:1'b0, ia:32'h0, lv:1'b1, la:32'h0000_0000, lw:1'b1, ld:32'hFFFF_FFFF, lm:4'h1, stall:0, lat:1};

        // Reset state, with both masters requesting
        #2; rst = 1'b1;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_ctrl", 64'({ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid,
                             mem_req_valid, mem_wen}), 64'(0));
        chk("rst_fields", 64'({mem_addr, mem_wmask}), 64'(0));
        chk("rst_wdata", 64'(mem_wdata), 64'(0));
        @(posedge clk); #3;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Both masters valid continuously for 4 transactions, from a fresh reset
        @(posedge clk); #3;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #3;
        rst = 1'b0; last_m = 1'b0; sb.delete();
        cfg_stall = 0; cfg_lat = 1;
        @(posedge clk); #1;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0200; lsu_wen = 1'b0; lsu_wmask = 4'h0;
        for (int t = 0; t < 4; t++) begin
            got = -1;
            for (int k = 1; k <= 12; k++) begin
                @(negedge clk); #2;
                if (ifu_req_ready || lsu_req_ready) begin got = k; break; end
            end
            if (got < 0) begin
                checks++; errors++;
                $display("FAIL contend_accept: no ready in transaction %0d", t);
                break;
            end
            el = !RR || !last_m;
            chk("contend_grant", 64'({ifu_req_ready, lsu_req_ready}), 64'(el ? 2'b01 : 2'b10));
            if (t > 0) chk("contend_spacing", 64'(got), 64'(3));
            last_m = el;
            sb.push_back('{el, rdata_for(el ? 32'h8000_0200 : 32'h8000_0100)});
        end
        @(posedge clk); #1;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        chk("contend_drain", 64'(sb.size()), 64'(0));

        // Reset while waiting for a slow response
        @(posedge clk); #1;
        cfg_stall = 0; cfg_lat = 20;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_5000; lsu_wen = 1'b1;
        lsu_wdata = 32'h0BAD_F00D; lsu_wmask = 4'hF;
        @(negedge clk); #2;
        chk("rstw_grant", 64'({ifu_req_ready, lsu_req_ready}), 64'(2'b01));
        sb.push_back('{1'b1, rdata_for(32'h8000_5000)});
        @(posedge clk); #1;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
        repeat (2) @(negedge clk);
        #2;
        chk("rstw_in_wait", 64'({mem_req_valid, ifu_req_ready, lsu_req_ready, mem_addr}),
            64'({3'b000, 32'h8000_5000}));
        #1; rst = 1'b1;
        #1;
        chk("rstw_ctrl", 64'({ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid,
                              mem_req_valid, mem_wen}), 64'(0));
        chk("rstw_fields", 64'({mem_addr, mem_wmask}), 64'(0));
        chk("rstw_data", 64'({mem_wdata, ifu_rdata | lsu_rdata}), 64'(0));
        sb.delete(); last_m = 1'b0;
        @(posedge clk); #3;
        rst = 1'b0; ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        run_vec(vecs[0], "post_rst");

        @(posedge clk); #1;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        repeat (25) @(negedge clk);
        #2;
        chk("final_drain", 64'(sb.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
